// File: rtl/fetch_pkg.sv
// Shared widths and types for the instruction fetch window.
// The address type is common to the cpu, the rom and the fetch logic.
package fetch_pkg;

    localparam int INSTR_W = 16;
    localparam int ADDR_W  = 10;

    typedef logic [ADDR_W-1:0]  addr_t;
    typedef logic [INSTR_W-1:0] instr_t;

    // Pointer width that stays legal for a single-entry buffer.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fetch_ring.sv
// Circular instruction store with a WINDOW-wide read port rooted at head.
// Contents are never reset; validity is tracked by the owner of the pointers.
module fetch_ring
    import fetch_pkg::*;
#(
    parameter int INSTR_WIDTH = INSTR_W,
    parameter int WINDOW      = 4,
    parameter int DEPTH       = 8,
    parameter int PW          = ptr_w(DEPTH)
) (
    input  logic                          clk,
    input  logic                          we_i,
    input  logic [PW-1:0]                 waddr_i,
    input  logic [INSTR_WIDTH-1:0]        wdata_i,
    input  logic [PW-1:0]                 head_i,
    output logic [WINDOW*INSTR_WIDTH-1:0] win_o
);

    logic [INSTR_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Slot addresses wrap naturally because DEPTH is a power of two.
    always_comb begin
        win_o = '0;
        for (int i = 0; i < WINDOW; i++) begin
            win_o[i*INSTR_WIDTH +: INSTR_WIDTH] = mem_q[head_i + PW'(i)];
        end
    end

endmodule

// File: rtl/fetch_window.sv
// Prefetch buffer feeding a window of consecutive instructions to the cpu
// from a single-port synchronous rom, with flush-and-refetch on redirect.
module fetch_window
    import fetch_pkg::*;
#(
    parameter int INSTR_WIDTH = INSTR_W,
    parameter int ADDR_WIDTH  = ADDR_W,
    parameter int WINDOW      = 4,
    parameter int DEPTH       = 8
) (
    input  logic                          clk,
    input  logic                          resetN,
    output logic [ADDR_WIDTH-1:0]         rom_addr,
    input  logic [INSTR_WIDTH-1:0]        rom_q,
    input  logic                          redirect,
    input  logic [ADDR_WIDTH-1:0]         redirect_pc,
    input  logic [$clog2(WINDOW+1)-1:0]   consume,
    output logic [ADDR_WIDTH-1:0]         win_pc,
    output logic [WINDOW*INSTR_WIDTH-1:0] win_inst,
    output logic [WINDOW-1:0]             win_valid
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0]         head_q, head_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  inflight_q, inflight_d;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0] win_pc_q, win_pc_d;

    logic          issue;
    logic          wr_en;
    logic [CW-1:0] take;
    logic [PW-1:0] tail;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            head_q     <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
            fetch_pc_q <= '0;
            win_pc_q   <= '0;
        end else begin
            head_q     <= head_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            fetch_pc_q <= fetch_pc_d;
            win_pc_q   <= win_pc_d;
        end
    end

    // Space is reserved for the in-flight word so the ring never overflows.
    always_comb begin
        take  = (CW'(consume) > count_q) ? count_q : CW'(consume);
        issue = !redirect &&
                (({1'b0, count_q} + {{CW{1'b0}}, inflight_q})
                 < (CW+1)'(DEPTH));
        wr_en = inflight_q && !redirect;
        tail  = head_q + count_q[PW-1:0];

        head_d     = head_q + take[PW-1:0];
        count_d    = count_q - take + CW'(wr_en);
        win_pc_d   = win_pc_q + ADDR_WIDTH'(take);
        fetch_pc_d = issue ? fetch_pc_q + ADDR_WIDTH'(1) : fetch_pc_q;
        inflight_d = issue;

        // The target itself goes out this cycle, so its word is in flight.
        if (redirect) begin
            count_d    = '0;
            win_pc_d   = redirect_pc;
            fetch_pc_d = redirect_pc + ADDR_WIDTH'(1);
            inflight_d = 1'b1;
        end
    end

    always_comb begin
        if (!resetN) begin
            rom_addr = '0;
        end else if (redirect) begin
            rom_addr = redirect_pc;
        end else begin
            rom_addr = fetch_pc_q;
        end
    end

    always_comb begin
        win_valid = '0;
        for (int i = 0; i < WINDOW; i++) begin
            win_valid[i] = count_q > CW'(i);
        end
    end

    assign win_pc = win_pc_q;

    fetch_ring #(
        .INSTR_WIDTH (INSTR_WIDTH),
        .WINDOW      (WINDOW),
        .DEPTH       (DEPTH),
        .PW          (PW)
    ) u_ring (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (tail),
        .wdata_i (rom_q),
        .head_i  (head_q),
        .win_o   (win_inst)
    );

endmodule

// File: doc/fetch_window.md
FETCH_WINDOW -- requirements
Module: fetch_window

Interface
REQ-001 Parameter INSTR_WIDTH, default 16: instruction width in bits.
REQ-002 Parameter ADDR_WIDTH, default 10: ROM address width in bits (1024 words).
REQ-003 Parameter WINDOW, default 4: number of consecutive instructions presented to the CPU.
REQ-004 Parameter DEPTH, default 8: buffer entries; power of two; DEPTH >= WINDOW.
REQ-005 clk  in  1: the one clock; all state changes on the rising edge.
REQ-006 resetN  in  1: asynchronous, active-low reset.
REQ-007 rom_addr  out  ADDR_WIDTH: address to a single synchronous ROM port.
REQ-008 rom_q  in  INSTR_WIDTH: ROM data, valid the cycle after rom_addr was presented.
REQ-009 redirect  in  1: CPU jump taken; flush and refetch.
REQ-010 redirect_pc  in  ADDR_WIDTH: jump target, sampled when redirect=1.
REQ-011 consume  in  $clog2(WINDOW+1): instructions retired by the CPU this cycle.
REQ-012 win_pc  out  ADDR_WIDTH: address of window slot 0.
REQ-013 win_inst  out  WINDOW*INSTR_WIDTH: slot i in bits [i*INSTR_WIDTH +: INSTR_WIDTH] = instruction at win_pc+i.
REQ-014 win_valid  out  WINDOW: bit i high when slot i holds valid data.

Function
REQ-015 The block SHALL keep a circular buffer of DEPTH entries with head pointer, count, and fetch_pc (next address to request).
REQ-016 issue = !redirect && (count + inflight < DEPTH); rom_addr SHALL be redirect_pc when redirect=1, else fetch_pc (combinational).
REQ-017 On issue, fetch_pc SHALL increment by 1 modulo 2**ADDR_WIDTH (1023 -> 0); inflight is set the next cycle.
REQ-018 When inflight=1 and no redirect occurs in that cycle, rom_q SHALL be written at tail = head+count (mod DEPTH).
REQ-019 win_valid[i] = (i < count); win_inst slot i = buffer[(head+i) mod DEPTH]; invalid slots are don't-care.
REQ-020 Effective consume = min(consume, count); head and win_pc SHALL advance by that amount (win_pc mod 2**ADDR_WIDTH).
REQ-021 Simultaneous write and consume: count_next = count - consume_eff + write.
REQ-022 Redirect SHALL take priority over consume and write: count <- 0, inflight <- 0 (in-flight data dropped), win_pc <- redirect_pc, fetch_pc <- redirect_pc+1, inflight set if redirect_pc issued.
REQ-023 After redirect in cycle t, target instruction SHALL be valid in slot 0 at cycle t+2; steady-state fill rate 1 instruction/cycle.
REQ-024 Full: while count + inflight = DEPTH no issue occurs; no entry is ever overwritten before consumption.
REQ-025 Redirect in consecutive cycles: only the last target is fetched; earlier in-flight data never becomes valid.

Reset
REQ-026 With resetN low: count=0, head=0, inflight=0, fetch_pc=0, win_pc=0, win_valid=0, rom_addr=0; buffer contents not reset.
REQ-027 Reset assertion mid-fetch SHALL discard all buffered and in-flight data immediately (asynchronous).
REQ-028 After deassertion, address 0 is issued the first cycle; win_valid[0] rises two cycles later.

Structure
REQ-029 Package fetch_pkg SHALL hold default INSTR_WIDTH/ADDR_WIDTH constants and the address typedef shared with cpu and rom instantiation.
REQ-030 Storage plus WINDOW-wide read mux SHALL be a sub-module fetch_ring; pointers, count, and issue control stay in fetch_window.

Verification
REQ-031 ROM model with mem[a]=16'hA000+a; reset release, consume=0 -> win_valid=4'b1111 by cycle 5, win_inst slots A000..A003, rom_addr stops at 8.
REQ-032 Steady consume=1 every cycle after fill -> win_pc increments by 1 per cycle, slot 0 = A000+win_pc, win_valid[0] never drops.
REQ-033 redirect=1, redirect_pc=10'h3FE with data in flight -> win_valid=0 next cycle; slot 0 = A3FE at t+2; subsequent slots A3FF, A000 (wrap).
REQ-034 consume=4 with count=2 -> count=0, win_pc+2, no underflow.
REQ-035 redirect to 20 then to 40 in consecutive cycles -> first valid slot 0 = A028, A014 never valid.
REQ-036 resetN pulsed low mid-fill -> win_valid=0 and rom_addr=0 within the same cycle; refill restarts at address 0.
